piradip_axis_sample_buffer_reader: RTL

Stream-clock playback engine for the sample buffer: the read side of the control words the sample-buffer CSR sends across its CDC. It walks a buffer RAM read port from a start offset to an end offset, in one-shot or continuous mode, and presents the words on an AXI4-Stream manager with full backpressure. It reports status back to the CSR through `stopped` and `wrap_toggle`.

---
 rtl/piradip_axis_sample_buffer_reader.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/piradip_axis_sample_buffer_reader.sv
// Sample-buffer playback: walks a RAM read port from start to end offset
// and streams words on AXI4-Stream with full backpressure.
//
// Ports:
//   aclk, aresetn          clock, async active-low reset
//   update/active/one_shot control strobe and qualified fields
//   start/end_offset       pass bounds, shadowed on every update
//   i_en, q_en             per-lane I/Q enables, applied at FIFO write
//   stopped, wrap_toggle   status back to the CSR
//   mem_en/addr/rdata      buffer RAM read port (RAM_LATENCY cycles)
//   m_axis_*               AXI4-Stream manager
//
// Build option: PIRADIP_SAMPLE_READER_TLAST_EN drives m_axis_tlast on the
// beat read from the pass end offset; otherwise tlast is tied low.

module piradip_axis_sample_buffer_reader #(
  parameter int STREAM_DATA_WIDTH   = 128,
  parameter int STREAM_OFFSET_WIDTH = 12,
  parameter int RAM_LATENCY         = 2
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           update,
  input  logic                           active,
  input  logic                           one_shot,
  input  logic [STREAM_OFFSET_WIDTH-1:0] start_offset,
  input  logic [STREAM_OFFSET_WIDTH-1:0] end_offset,
  input  logic                           i_en,
  input  logic                           q_en,
  output logic                           stopped,
  output logic                           wrap_toggle,
  output logic                           mem_en,
  output logic [STREAM_OFFSET_WIDTH-1:0] mem_addr,
  input  logic [STREAM_DATA_WIDTH-1:0]   mem_rdata,
  output logic [STREAM_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast
);

  localparam int DW    = STREAM_DATA_WIDTH;
  localparam int OW    = STREAM_OFFSET_WIDTH;
  localparam int L     = RAM_LATENCY;
  localparam int DEPTH = L + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int LANES = DW / 32;

  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state;
  logic          sh_one_shot;
  logic [OW-1:0] sh_start;
  logic [OW-1:0] sh_end;
  logic [OW-1:0] ptr;
  logic [OW-1:0] pass_end;
  logic          wrap_q;

  logic [L-1:0]  vpipe;
  logic [DW-1:0] fifo_data [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;

  logic          trig;
  logic          credit;
  logic          issue;
  logic          at_end;
  logic          push;
  logic          pop;
  logic          drained;
  logic [DW-1:0] masked;

  assign trig   = update & active;
  assign at_end = (ptr == pass_end);
  assign push   = vpipe[L-1];
  assign pop    = m_axis_tvalid & m_axis_tready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < L; i++)
      inflight = inflight + CW'(vpipe[i]);
  end

  // Reads in flight plus words held may never exceed the FIFO depth,
  // so every returned word has a slot waiting for it.
  assign credit = ({1'b0, inflight} + {1'b0, count}) < DEPTH_V;
  assign issue  = (state == S_RUN) & credit;

  // Leave DRAIN on the cycle the last held word is taken.
  assign drained = (inflight == '0) &&
                   ((count == '0) || ((count == CW'(1)) && pop));

  assign mem_en      = issue;
  assign mem_addr    = ptr;
  assign stopped     = (state == S_IDLE);
  assign wrap_toggle = wrap_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sh_one_shot <= 1'b0;
      sh_start    <= '0;
      sh_end      <= '1;
    end else if (update) begin
      sh_one_shot <= one_shot;
      sh_start    <= start_offset;
      sh_end      <= end_offset;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= S_IDLE;
      ptr      <= '0;
      pass_end <= '0;
      wrap_q   <= 1'b0;
    end else if (trig) begin
      // Retrigger beats a coincident end of pass: no toggle.
      state    <= S_RUN;
      ptr      <= start_offset;
      pass_end <= end_offset;
    end else begin
      unique case (state)
        S_IDLE: ;
        S_RUN: begin
          if (issue) begin
            if (at_end) begin
              wrap_q <= ~wrap_q;
              if (sh_one_shot) begin
                state <= S_DRAIN;
              end else begin
                ptr      <= sh_start;
                pass_end <= sh_end;
              end
            end else begin
              ptr <= ptr + OW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drained)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= issue;
      for (int i = 1; i < L; i++)
        vpipe[i] <= vpipe[i-1];
    end
  end

  always_comb begin
    masked = mem_rdata;
    for (int k = 0; k < LANES; k++) begin
      if (!i_en) masked[32*k +: 16]      = '0;
      if (!q_en) masked[32*k + 16 +: 16] = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push)
        wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + PW'(1);
      if (pop)
        rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge aclk) begin
    if (push)
      fifo_data[wp] <= masked;
  end

  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? fifo_data[rp] : '0;

`ifdef PIRADIP_SAMPLE_READER_TLAST_EN
  logic [L-1:0] lpipe;
  logic         fifo_last [DEPTH];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lpipe <= '0;
    end else begin
      lpipe[0] <= issue & at_end;
      for (int i = 1; i < L; i++)
        lpipe[i] <= lpipe[i-1];
    end
  end

  always_ff @(posedge aclk) begin
    if (push)
      fifo_last[wp] <= lpipe[L-1];
  end

  assign m_axis_tlast = m_axis_tvalid & fifo_last[rp];
`else
  assign m_axis_tlast = 1'b0;
`endif

endmodule
